// File: rtl/pwm_duty_ramp_if.sv
// Command channel into the duty ramp stage.
//
// Handshake: a command transfers on every rising clock edge where
// cmd_valid and cmd_ready are both 1. cmd_duty is only meaningful while
// cmd_valid is 1. cmd_ready does not depend on cmd_valid.
//
// Signals:
//   cmd_valid  master -> slave  command present
//   cmd_duty   master -> slave  requested duty (W bits)
//   cmd_ready  slave -> master  command accepted this cycle if cmd_valid
interface pwm_duty_ramp_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic [W-1:0] cmd_duty;
    logic         cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_duty,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_duty,
        output cmd_ready
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// Duty-command stage in front of the motor PWM generator.
//
// Holds duty at zero through an ESC arming interval of ARM_PERIODS PWM
// periods. After that it accepts throttle commands, clamps them to
// MAX_DUTY and slews the presented duty toward the command by at most
// STEP per PWM period. Duty only moves on period_end, so the generator
// never sees a mid-period change.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_n       asynchronous active-low reset
//   arm         level: 1 = arm/run, 0 = force disarm
//   period_end  one-cycle pulse at each PWM period wrap
//   cmd         command channel (slave side of pwm_duty_ramp_if)
//   duty        registered duty to the PWM stage
//   running     state is RUN
//   settled     running and duty has reached the target
//   clamp_err   one-cycle pulse: accepted command exceeded MAX_DUTY
//   state_dbg   current FSM state (0 DISARMED, 1 ARMING, 2 RUN)
module pwm_duty_ramp #(
    parameter int W           = 8,
    parameter int MAX_DUTY    = 100,
    parameter int STEP        = 5,
    parameter int ARM_PERIODS = 50
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              period_end,
    pwm_duty_ramp_if.slave    cmd,
    output logic [W-1:0]      duty,
    output logic              running,
    output logic              settled,
    output logic              clamp_err,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam int           CW       = $clog2(ARM_PERIODS + 1);
    localparam logic [CW-1:0] ARM_LAST = CW'(ARM_PERIODS - 1);
    localparam logic [W:0]   MAX_EXT  = (W+1)'(MAX_DUTY);
    localparam logic [W-1:0] MAX_D    = W'(MAX_DUTY);
    localparam logic [W:0]   STEP_EXT = (W+1)'(STEP);
    localparam logic [W-1:0] STEP_D   = W'(STEP);

    state_t        state_q, state_d;
    logic [CW-1:0] arm_cnt_q, arm_cnt_d;
    logic [W-1:0]  target_q, target_d;
    logic [W-1:0]  duty_q, duty_d;
    logic          clamp_err_q, clamp_err_d;

    // Slew arithmetic, widened by one bit so neither add nor compare wraps.
    logic [W:0]    up_sum;
    logic [W:0]    dn_floor;
    logic [W-1:0]  step_duty;
    logic          cmd_over;
    logic [W-1:0]  cmd_clamped;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= DISARMED;
            arm_cnt_q   <= '0;
            target_q    <= '0;
            duty_q      <= '0;
            clamp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            target_q    <= target_d;
            duty_q      <= duty_d;
            clamp_err_q <= clamp_err_d;
        end
    end

    always_comb begin
        up_sum      = {1'b0, duty_q} + STEP_EXT;
        dn_floor    = {1'b0, target_q} + STEP_EXT;
        cmd_over    = {1'b0, cmd.cmd_duty} > MAX_EXT;
        cmd_clamped = cmd_over ? MAX_D : cmd.cmd_duty;

        step_duty = duty_q;
        if (duty_q < target_q) begin
            step_duty = (up_sum > {1'b0, target_q}) ? target_q : up_sum[W-1:0];
        end else if (duty_q > target_q) begin
            // duty >= target + STEP guarantees duty - STEP cannot underflow.
            step_duty = ({1'b0, duty_q} < dn_floor) ? target_q : (duty_q - STEP_D);
        end

        state_d     = state_q;
        arm_cnt_d   = arm_cnt_q;
        target_d    = target_q;
        duty_d      = duty_q;
        clamp_err_d = 1'b0;

        unique case (state_q)
            DISARMED: begin
                duty_d   = '0;
                target_d = '0;
                if (arm) begin
                    state_d   = ARMING;
                    arm_cnt_d = '0;
                end
            end
            ARMING: begin
                duty_d   = '0;
                target_d = '0;
                if (!arm) begin
                    state_d = DISARMED;
                end else if (period_end) begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                    if (arm_cnt_q == ARM_LAST) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                // Disarm overrides any accept or period step on the same edge.
                if (!arm) begin
                    state_d  = DISARMED;
                    duty_d   = '0;
                    target_d = '0;
                end else begin
                    // The step always uses the target from before this edge.
                    if (period_end) begin
                        duty_d = step_duty;
                    end
                    if (cmd.cmd_valid) begin
                        target_d    = cmd_clamped;
                        clamp_err_d = cmd_over;
                    end
                end
            end
            default: begin
                state_d  = DISARMED;
                duty_d   = '0;
                target_d = '0;
            end
        endcase
    end

    always_comb begin
        cmd.cmd_ready = (state_q == RUN);
        running       = (state_q == RUN);
        settled       = (state_q == RUN) && (duty_q == target_q);
        duty          = duty_q;
        clamp_err     = clamp_err_q;
        state_dbg     = state_q;
    end

endmodule
